gact_tb_collector: RTL and testbench

GACT_TB_COLLECTOR -- requirements
Module: gact_tb_collector

---
 rtl/gact_tb_collector_pkg.sv | 56 +++++
 rtl/gact_tb_collector_fifo.sv | 69 ++++++
 rtl/gact_tb_collector.sv | 174 +++++++++++++++++
 tb/tb_gact_tb_collector.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gact_tb_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gact_tb_collector_pkg
// Purpose  : Shared types and constants for the GACT traceback collector:
//            FSM state encoding, packing geometry, trailer field widths and
//            helper functions that assemble the four trailer words.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gact_tb_collector_pkg;

  // Collector FSM states
  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_TRL0    = 3'd2,
    ST_TRL1    = 3'd3,
    ST_TRL2    = 3'd4,
    ST_TRL3    = 3'd5,
    ST_CLEAR   = 3'd6
  } state_t;

  // Packing geometry
  localparam int DIRS_PER_WORD = 16;
  localparam int DIR_W         = 2;
  localparam int SLOT_W        = 4;
  localparam int WORD_W        = 32;
  localparam int FIFO_W        = WORD_W + 1;   // data + last tag

  // Trailer field widths
  localparam int REQ_ID_FIELD_W = 16;
  localparam int SCORE_W        = 10;
  localparam int POS_W          = 9;
  localparam int NBASES_W       = 9;
  localparam int TB_STEPS_W     = 18;

  // TRL0: {req_id, 6'b0, tile_score}
  function automatic logic [WORD_W-1:0] trl0_word(input logic [REQ_ID_FIELD_W-1:0] rid,
                                                  input logic [SCORE_W-1:0] score);
    return {rid, 6'b0, score};
  endfunction

  // TRL1 / TRL2: two 9-bit fields, each in the low bits of a 16-bit half
  function automatic logic [WORD_W-1:0] pair9_word(input logic [POS_W-1:0] hi,
                                                   input logic [POS_W-1:0] lo);
    return {7'b0, hi, 7'b0, lo};
  endfunction

  // TRL3: {overflow, 13'b0, num_tb_steps}
  function automatic logic [WORD_W-1:0] trl3_word(input logic ovf,
                                                  input logic [TB_STEPS_W-1:0] steps);
    return {ovf, 13'b0, steps};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gact_tb_collector_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gact_sync_fifo
// Purpose  : Single-clock FIFO with full/empty/count status. Head word is
//            presented combinationally on o_rdata.
// Ports    : clk, rst (async, active-high)
//            i_push/i_wdata  - write side; accepted when not full or popping
//            i_pop           - read side; ignored when empty
//            o_rdata         - head entry
//            o_full, o_empty, o_count - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module gact_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gact_tb_collector.sv
`default_nettype none
// ============================================================================
// Module   : gact_tb_collector
// Purpose  : Packs 2-bit traceback directions from the GACT core into 32-bit
//            words, then appends four trailer words with the tile result and
//            acknowledges the core with a clear_done pulse.
// Ports    : clk, rst (async, active-high)
//            dir/dir_valid        - direction stream from the core
//            done + result fields - tile completion and result, held by core
//            clear_done           - one-cycle acknowledge of done
//            out_data/out_valid/out_ready/out_last - output word stream
//            overflow             - sticky: a direction word was dropped
// Revision : 1.0 - initial release
// ============================================================================
module gact_tb_collector
  import gact_tb_collector_pkg::*;
#(
  parameter int FIFO_DEPTH       = 32,
  parameter int REQUEST_ID_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  dir,
  input  logic                        dir_valid,
  input  logic                        done,
  input  logic [REQUEST_ID_WIDTH-1:0] req_id_out,
  input  logic [SCORE_W-1:0]          tile_score,
  input  logic [POS_W-1:0]            ref_max_pos,
  input  logic [POS_W-1:0]            query_max_pos,
  input  logic [NBASES_W-1:0]         num_ref_bases,
  input  logic [NBASES_W-1:0]         num_query_bases,
  input  logic [TB_STEPS_W-1:0]       num_tb_steps,
  output logic                        clear_done,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t              r_state;
  state_t              w_next;
  logic [SLOT_W-1:0]   r_slot;
  logic [WORD_W-1:0]   r_pack;
  logic                r_pend;        // completed word waiting to enter the FIFO
  logic [WORD_W-1:0]   r_pend_word;
  logic                r_overflow;

  logic                w_push;
  logic [FIFO_W-1:0]   w_wdata;
  logic                w_drop;
  logic                w_flush_clr;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [FIFO_W-1:0]   w_rdata;
  logic                w_pop;
  logic                w_room;
  logic                w_collect_dv;
  logic [15:0]         w_rid16;

  assign w_rid16      = 16'(req_id_out);
  assign w_pop        = out_valid && out_ready;
  assign w_room       = !w_full || w_pop;
  assign w_collect_dv = (r_state == ST_COLLECT) && dir_valid;

  assign out_valid  = (w_count != '0);
  assign out_data   = w_empty ? '0 : w_rdata[WORD_W-1:0];
  assign out_last   = w_empty ? 1'b0 : w_rdata[WORD_W];
  assign clear_done = (r_state == ST_CLEAR);
  assign overflow   = r_overflow;

  // Next-state and FIFO write arbitration. A pending direction word always
  // goes first (or is dropped) so it never lands behind a partial or trailer.
  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_wdata     = '0;
    w_drop      = 1'b0;
    w_flush_clr = 1'b0;
    if (r_pend) begin
      w_push  = w_room;
      w_drop  = !w_room;
      w_wdata = {1'b0, r_pend_word};
    end
    case (r_state)
      ST_COLLECT: if (done) w_next = ST_FLUSH;
      ST_FLUSH: begin
        if (!r_pend) begin
          if (r_slot == '0) begin
            w_next = ST_TRL0;
          end else if (w_room) begin
            w_push      = 1'b1;
            w_wdata     = {1'b0, r_pack};
            w_flush_clr = 1'b1;
            w_next      = ST_TRL0;
          end
        end
      end
      ST_TRL0: if (!r_pend && w_room) begin
        w_push  = 1'b1;
        w_wdata = {1'b0, trl0_word(w_rid16, tile_score)};
        w_next  = ST_TRL1;
      end
      ST_TRL1: if (!r_pend && w_room) begin
        w_push  = 1'b1;
        w_wdata = {1'b0, pair9_word(ref_max_pos, query_max_pos)};
        w_next  = ST_TRL2;
      end
      ST_TRL2: if (!r_pend && w_room) begin
        w_push  = 1'b1;
        w_wdata = {1'b0, pair9_word(num_ref_bases, num_query_bases)};
        w_next  = ST_TRL3;
      end
      ST_TRL3: if (!r_pend && w_room) begin
        w_push  = 1'b1;
        w_wdata = {1'b1, trl3_word(r_overflow, num_tb_steps)};
        w_next  = ST_CLEAR;
      end
      ST_CLEAR: w_next = ST_COLLECT;
      default:  w_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_COLLECT;
      r_slot      <= '0;
      r_pack      <= '0;
      r_pend      <= 1'b0;
      r_pend_word <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Pending word lives exactly one cycle: pushed or dropped
      r_pend  <= w_collect_dv && (r_slot == SLOT_W'(DIRS_PER_WORD-1));
      if (w_collect_dv) begin
        if (r_slot == SLOT_W'(DIRS_PER_WORD-1)) begin
          // Upper two bits are still zero, so the new dir drops straight in
          r_pend_word <= {dir, r_pack[WORD_W-3:0]};
          r_pack      <= '0;
          r_slot      <= '0;
        end else begin
          r_pack[{r_slot, 1'b0} +: DIR_W] <= dir;
          r_slot <= r_slot + 1'b1;
        end
      end else if (w_flush_clr) begin
        r_pack <= '0;
        r_slot <= '0;
      end
      if (r_state == ST_CLEAR) r_overflow <= 1'b0;
      else if (w_drop)         r_overflow <= 1'b1;
    end
  end

  gact_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_gact_tb_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_gact_tb_collector
// Purpose  : Scoreboard bench for gact_tb_collector. Expected words are
//            derived from the list of directions and result fields of each
//            tile; a monitor pops and compares every accepted output word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gact_tb_collector;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dir;
  logic        dir_valid;
  logic        done;
  logic [15:0] req_id_out;
  logic [9:0]  tile_score;
  logic [8:0]  ref_max_pos, query_max_pos, num_ref_bases, num_query_bases;
  logic [17:0] num_tb_steps;
  logic        clear_done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        overflow;

  gact_tb_collector #(.FIFO_DEPTH(DEPTH), .REQUEST_ID_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .dir(dir), .dir_valid(dir_valid), .done(done),
    .req_id_out(req_id_out), .tile_score(tile_score),
    .ref_max_pos(ref_max_pos), .query_max_pos(query_max_pos),
    .num_ref_bases(num_ref_bases), .num_query_bases(num_query_bases),
    .num_tb_steps(num_tb_steps), .clear_done(clear_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_clr = 0;
  int          rdy_mode = 0;      // 0: always ready, 1: random, 2: held low
  logic [32:0] expq[$];
  logic [1:0]  dirs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready driver: changes just after each rising edge
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares accepted words, checks stall stability and pulse width
  initial begin
    logic        stall;
    logic [32:0] held;
    logic        prev_clr;
    logic [32:0] e;
    stall = 1'b0; held = '0; prev_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
        prev_clr = 1'b0;
      end else begin
        if (stall) check("stall_stable", {out_valid, out_last, out_data}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_word: got %0h expected none", {out_last, out_data});
          end else begin
            e = expq.pop_front();
            check("out_word", {out_last, out_data}, e);
          end
        end
        stall = out_valid && !out_ready;
        held  = {out_last, out_data};
        if (clear_done) begin
          check("clear_done_width", prev_clr, 0);
          n_clr++;
        end
        prev_clr = clear_done;
      end
    end
  end

  task automatic gen_dirs(input int n, input int mode);
    dirs.delete();
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       dirs.push_back(2'(i % 4));
        1:       dirs.push_back(2'b11);
        default: dirs.push_back(2'($urandom_range(0, 3)));
      endcase
    end
  endtask

  task automatic rand_fields();
    req_id_out      = 16'($urandom);
    tile_score      = 10'($urandom);
    ref_max_pos     = 9'($urandom);
    query_max_pos   = 9'($urandom);
    num_ref_bases   = 9'($urandom);
    num_query_bases = 9'($urandom);
    num_tb_steps    = 18'($urandom);
  endtask

  // Reference: 16 dirs per word, first dir in the lowest bits; full words
  // beyond 'limit' are lost; then the four trailers.
  task automatic push_expected(input int limit, input bit ovf);
    int          n;
    int          nw;
    logic [31:0] w;
    n  = dirs.size();
    nw = (n + 15) / 16;
    for (int k = 0; k < nw; k++) begin
      w = 0;
      for (int j = 0; j < 16 && 16 * k + j < n; j++) w = w + (32'(dirs[16 * k + j]) << (2 * j));
      if (k < limit) expq.push_back({1'b0, w});
    end
    expq.push_back({1'b0, req_id_out, 6'b0, tile_score});
    expq.push_back({1'b0, 7'b0, ref_max_pos, 7'b0, query_max_pos});
    expq.push_back({1'b0, 7'b0, num_ref_bases, 7'b0, num_query_bases});
    expq.push_back({1'b1, ovf, 13'b0, num_tb_steps});
  endtask

  // Called just after a rising edge; returns just after a rising edge
  task automatic drive_dirs(input bit dense, input bit same_done, input bit ovf_probe);
    for (int i = 0; i < dirs.size(); i++) begin
      if (!dense) begin
        while ($urandom_range(0, 3) == 0) begin
          dir_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      dir = dirs[i];
      dir_valid = 1'b1;
      if (same_done && i == dirs.size() - 1) done = 1'b1;
      @(posedge clk); #1;
      if (ovf_probe && i == 139) check("overflow_before_9th", overflow, 0);
    end
    dir_valid = 1'b0;
    dir = 2'b00;
  endtask

  task automatic finish_tile();
    int clr0;
    int t;
    clr0 = n_clr;
    done = 1'b1;
    t = 0;
    while (!clear_done && t < 3000) begin @(negedge clk); t++; end
    check("clear_done_seen", clear_done, 1);
    done = 1'b0;
    t = 0;
    while (expq.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    check("queue_drained", expq.size(), 0);
    repeat (4) @(negedge clk);
    check("clear_done_count", n_clr - clr0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_tile(input int n, input int mode, input bit dense, input bit same_done);
    rand_fields();
    gen_dirs(n, mode);
    push_expected(1 << 30, 1'b0);
    drive_dirs(dense, same_done, 1'b0);
    finish_tile();
  endtask

  initial begin
    int clr0;
    rst = 1'b1; dir = 2'b00; dir_valid = 1'b0; done = 1'b0;
    rand_fields();
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Pattern k%4, with the 2-cycle latency to out_valid
    rand_fields();
    gen_dirs(16, 0);
    push_expected(1 << 30, 1'b0);
    drive_dirs(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_cycle1", out_valid, 0);
    @(negedge clk);
    check("latency_cycle2", out_valid, 1);
    @(posedge clk); #1;
    finish_tile();

    // Partial word of five 2'b11
    run_tile(5, 1, 1'b1, 1'b0);

    // done together with the 16th dir
    run_tile(16, 2, 1'b1, 1'b1);

    // Random backpressure over 400 sparse dirs
    rdy_mode = 1;
    run_tile(400, 2, 1'b0, 1'b0);

    // Overflow: output held off, 160 dirs into an 8-deep buffer
    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    rand_fields();
    gen_dirs(160, 2);
    push_expected(DEPTH, 1'b1);
    drive_dirs(1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("overflow_set", overflow, 1);
    rdy_mode = 1;
    finish_tile();
    check("overflow_cleared", overflow, 0);

    // Reset while stuck in TRL1 (7 words + TRL0 fill the buffer)
    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    rand_fields();
    gen_dirs(112, 2);
    drive_dirs(1'b1, 1'b0, 1'b0);
    done = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1);
    clr0 = n_clr;
    rst = 1'b1;
    expq.delete();
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_clear_done", clear_done, 0);
    done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("no_clear_after_rst", n_clr - clr0, 0);
    check("no_output_after_rst", out_valid, 0);
    rdy_mode = 1;
    run_tile(37, 2, 1'b0, 1'b0);

    // A few more random tiles
    for (int r = 0; r < 3; r++) run_tile(int'($urandom_range(1, 60)), 2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
